// File: rtl/dmi_pkg.sv
// Shared DMI definitions: payload widths, op/resp encodings, arbiter states
// and the request/response holding-register structs.
package dmi_pkg;

   localparam int DMI_ADDR_W = 7;
   localparam int DMI_DATA_W = 32;

   typedef enum logic [1:0] {
      DMI_OP_NOP   = 2'd0,
      DMI_OP_READ  = 2'd1,
      DMI_OP_WRITE = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      DMI_RESP_SUCCESS = 2'd0,
      DMI_RESP_FAILED  = 2'd2,
      DMI_RESP_BUSY    = 2'd3
   } dmi_resp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } dmi_arb_state_e;

   typedef struct packed {
      logic [DMI_ADDR_W-1:0] addr;
      logic [1:0]            op;
      logic [DMI_DATA_W-1:0] data;
   } dmi_req_t;

   typedef struct packed {
      logic [1:0]            resp;
      logic [DMI_DATA_W-1:0] data;
   } dmi_resp_t;

endpackage

// File: rtl/dmi_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, on contention the
// requester that was not granted last wins.
module dmi_rr_pick (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       idx
);

   // Winner index first, then a one-hot grant only when someone is asking
   always_comb begin
      idx   = 1'b0;
      grant = 2'b00;
      case (valid)
         2'b01:   idx = 1'b0;
         2'b10:   idx = 1'b1;
         2'b11:   idx = ~last_grant;
         default: idx = 1'b0;
      endcase
      if (|valid) begin
         grant = idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmi_arbiter.sv
// Arbitrates two DMI requesters onto one downstream DMI port, one transaction
// at a time. Optional WAIT timeout with late-response drain: DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
   import dmi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        rq0_req_valid,
   output logic        rq0_req_ready,
   input  logic [6:0]  rq0_req_bits_addr,
   input  logic [1:0]  rq0_req_bits_op,
   input  logic [31:0] rq0_req_bits_data,
   output logic        rq0_resp_valid,
   input  logic        rq0_resp_ready,
   output logic [1:0]  rq0_resp_bits_resp,
   output logic [31:0] rq0_resp_bits_data,

   input  logic        rq1_req_valid,
   output logic        rq1_req_ready,
   input  logic [6:0]  rq1_req_bits_addr,
   input  logic [1:0]  rq1_req_bits_op,
   input  logic [31:0] rq1_req_bits_data,
   output logic        rq1_resp_valid,
   input  logic        rq1_resp_ready,
   output logic [1:0]  rq1_resp_bits_resp,
   output logic [31:0] rq1_resp_bits_data,

   output logic        dmi_req_valid,
   input  logic        dmi_req_ready,
   output logic [6:0]  dmi_req_bits_addr,
   output logic [1:0]  dmi_req_bits_op,
   output logic [31:0] dmi_req_bits_data,
   input  logic        dmi_resp_valid,
   output logic        dmi_resp_ready,
   input  logic [1:0]  dmi_resp_bits_resp,
   input  logic [31:0] dmi_resp_bits_data,

   output logic        busy,
   output logic        owner
);

   dmi_arb_state_e state_q, state_d;
   logic           lastGrant_q, lastGrant_d;
   logic           owner_q, owner_d;
   dmi_req_t       req_q, req_d;
   dmi_resp_t      resp_q, resp_d;
   logic [1:0]     reqValid;
   logic [1:0]     pickGrant;
   logic           pickIdx;
   logic           drainPending;

   assign reqValid = {rq1_req_valid, rq0_req_valid};

   dmi_rr_pick uPick (
      .valid      (reqValid),
      .last_grant (lastGrant_q),
      .grant      (pickGrant),
      .idx        (pickIdx)
   );

`ifdef DMI_ARB_TIMEOUT_EN
   logic        drain_q, drain_d;
   logic [31:0] timeoutCnt_q, timeoutCnt_d;
   logic        timeoutHit;

   assign drainPending = drain_q;
   assign timeoutHit   = (timeoutCnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Counter only runs while WAIT is idle; any other state or a response clears it
   always_comb begin
      timeoutCnt_d = 32'd0;
      if (state_q == ST_WAIT && !dmi_resp_valid) begin
         timeoutCnt_d = timeoutCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drain_q      <= 1'b0;
         timeoutCnt_q <= 32'd0;
      end else begin
         drain_q      <= drain_d;
         timeoutCnt_q <= timeoutCnt_d;
      end
   end
`else
   logic unusedTimeoutParam;

   assign drainPending       = 1'b0;
   assign unusedTimeoutParam = (TIMEOUT_CYCLES == 0);
`endif

   // State and holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         req_q       <= '0;
         resp_q      <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         owner_q     <= owner_d;
         req_q       <= req_d;
         resp_q      <= resp_d;
      end
   end

   // Next state and handshakes; everything is forced quiet while reset is high
   always_comb begin
      state_d        = state_q;
      lastGrant_d    = lastGrant_q;
      owner_d        = owner_q;
      req_d          = req_q;
      resp_d         = resp_q;
      rq0_req_ready  = 1'b0;
      rq1_req_ready  = 1'b0;
      rq0_resp_valid = 1'b0;
      rq1_resp_valid = 1'b0;
      dmi_req_valid  = 1'b0;
      dmi_resp_ready = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
      drain_d        = drain_q;
`endif
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (!drainPending && (|reqValid)) begin
                  rq0_req_ready = pickGrant[0];
                  rq1_req_ready = pickGrant[1];
                  lastGrant_d   = pickIdx;
                  owner_d       = pickIdx;
                  req_d         = pickIdx
                                  ? '{addr: rq1_req_bits_addr, op: rq1_req_bits_op, data: rq1_req_bits_data}
                                  : '{addr: rq0_req_bits_addr, op: rq0_req_bits_op, data: rq0_req_bits_data};
                  state_d       = ST_REQ;
               end
            end
            ST_REQ: begin
               dmi_req_valid = 1'b1;
               if (dmi_req_ready) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               dmi_resp_ready = 1'b1;
               if (dmi_resp_valid) begin
                  resp_d  = '{resp: dmi_resp_bits_resp, data: dmi_resp_bits_data};
                  state_d = ST_RESP;
               end
`ifdef DMI_ARB_TIMEOUT_EN
               else if (timeoutHit) begin
                  resp_d  = '{resp: DMI_RESP_FAILED, data: 32'd0};
                  drain_d = 1'b1;
                  state_d = ST_RESP;
               end
`endif
            end
            ST_RESP: begin
               if (owner_q) begin
                  rq1_resp_valid = 1'b1;
                  if (rq1_resp_ready) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  rq0_resp_valid = 1'b1;
                  if (rq0_resp_ready) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
`ifdef DMI_ARB_TIMEOUT_EN
         // The abandoned downstream response is swallowed outside WAIT
         if (drain_q && state_q != ST_WAIT) begin
            dmi_resp_ready = 1'b1;
            if (dmi_resp_valid) begin
               drain_d = 1'b0;
            end
         end
`endif
      end
   end

   assign busy  = !reset && ((state_q != ST_IDLE) || drainPending);
   assign owner = owner_q;

   assign dmi_req_bits_addr  = req_q.addr;
   assign dmi_req_bits_op    = req_q.op;
   assign dmi_req_bits_data  = req_q.data;
   assign rq0_resp_bits_resp = resp_q.resp;
   assign rq0_resp_bits_data = resp_q.data;
   assign rq1_resp_bits_resp = resp_q.resp;
   assign rq1_resp_bits_data = resp_q.data;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized self-checking bench for dmi_arbiter with a transaction-level
// reference model of the grant order and response routing.
module tb_dmi_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rq0_req_valid, rq0_req_ready, rq0_resp_valid, rq0_resp_ready;
   logic [6:0]  rq0_req_bits_addr;
   logic [1:0]  rq0_req_bits_op, rq0_resp_bits_resp;
   logic [31:0] rq0_req_bits_data, rq0_resp_bits_data;
   logic        rq1_req_valid, rq1_req_ready, rq1_resp_valid, rq1_resp_ready;
   logic [6:0]  rq1_req_bits_addr;
   logic [1:0]  rq1_req_bits_op, rq1_resp_bits_resp;
   logic [31:0] rq1_req_bits_data, rq1_resp_bits_data;
   logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
   logic [6:0]  dmi_req_bits_addr;
   logic [1:0]  dmi_req_bits_op, dmi_resp_bits_resp;
   logic [31:0] dmi_req_bits_data, dmi_resp_bits_data;
   logic        busy, owner;

   int total = 0;
   int bad   = 0;
   int lastWinner = 1;

   always #5 clk = ~clk;

   dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .rq0_req_valid(rq0_req_valid), .rq0_req_ready(rq0_req_ready),
      .rq0_req_bits_addr(rq0_req_bits_addr), .rq0_req_bits_op(rq0_req_bits_op),
      .rq0_req_bits_data(rq0_req_bits_data),
      .rq0_resp_valid(rq0_resp_valid), .rq0_resp_ready(rq0_resp_ready),
      .rq0_resp_bits_resp(rq0_resp_bits_resp), .rq0_resp_bits_data(rq0_resp_bits_data),
      .rq1_req_valid(rq1_req_valid), .rq1_req_ready(rq1_req_ready),
      .rq1_req_bits_addr(rq1_req_bits_addr), .rq1_req_bits_op(rq1_req_bits_op),
      .rq1_req_bits_data(rq1_req_bits_data),
      .rq1_resp_valid(rq1_resp_valid), .rq1_resp_ready(rq1_resp_ready),
      .rq1_resp_bits_resp(rq1_resp_bits_resp), .rq1_resp_bits_data(rq1_resp_bits_data),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_bits_addr(dmi_req_bits_addr), .dmi_req_bits_op(dmi_req_bits_op),
      .dmi_req_bits_data(dmi_req_bits_data),
      .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
      .dmi_resp_bits_resp(dmi_resp_bits_resp), .dmi_resp_bits_data(dmi_resp_bits_data),
      .busy(busy), .owner(owner)
   );

   task automatic clearInputs();
      rq0_req_valid = 0; rq0_resp_ready = 0; rq1_req_valid = 0; rq1_resp_ready = 0;
      rq0_req_bits_addr = 0; rq0_req_bits_op = 0; rq0_req_bits_data = 0;
      rq1_req_bits_addr = 0; rq1_req_bits_op = 0; rq1_req_bits_data = 0;
      dmi_req_ready = 0; dmi_resp_valid = 0; dmi_resp_bits_resp = 0; dmi_resp_bits_data = 0;
   endtask

   // One full transaction; the model picks the winner, the bench supplies the response
   task automatic doTxn(input bit v0, input bit v1, input bit keep, input int reqDelay,
                        input int waitDelay, input int respDelay,
                        input logic [6:0] fixA, input logic [1:0] fixR, input logic [31:0] fixD,
                        input bit useFix);
      int          winner;
      logic [6:0]  a0, a1, expA;
      logic [1:0]  o0, o1, expO, rr;
      logic [31:0] d0, d1, expD, rd;
      logic        rspV0, rspV1;
      logic [1:0]  rspR;
      logic [31:0] rspD;
      a0 = 7'($urandom); a1 = 7'($urandom); o0 = 2'($urandom_range(0, 2)); o1 = 2'($urandom_range(0, 2));
      d0 = $urandom; d1 = $urandom;
      case ($urandom_range(0, 2))
         0: rr = 2'd0;
         1: rr = 2'd2;
         default: rr = 2'd3;
      endcase
      rd = $urandom;
      if (useFix) begin a0 = fixA; o0 = 2'd1; rr = fixR; rd = fixD; end
      winner = (v0 && v1) ? (1 - lastWinner) : (v1 ? 1 : 0);
      lastWinner = winner;
      expA = winner ? a1 : a0; expO = winner ? o1 : o0; expD = winner ? d1 : d0;

      rq0_req_valid = v0; rq0_req_bits_addr = a0; rq0_req_bits_op = o0; rq0_req_bits_data = d0;
      rq1_req_valid = v1; rq1_req_bits_addr = a1; rq1_req_bits_op = o1; rq1_req_bits_data = d1;
      #1;
      total++; if (rq0_req_ready !== (winner == 0)) begin bad++; $display("[TB] FAIL grant_rdy0 got=%0b exp=%0b", rq0_req_ready, winner == 0); end
      total++; if (rq1_req_ready !== (winner == 1)) begin bad++; $display("[TB] FAIL grant_rdy1 got=%0b exp=%0b", rq1_req_ready, winner == 1); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%0b exp=0", busy); end
      @(posedge clk); #1;
      if (!keep) begin rq0_req_valid = 0; rq1_req_valid = 0; end

      for (int i = 0; i <= reqDelay; i++) begin
         dmi_req_ready = (i == reqDelay);
         #1;
         total++; if (dmi_req_valid !== 1'b1) begin bad++; $display("[TB] FAIL dmi_req_valid got=%0b exp=1", dmi_req_valid); end
         total++; if ({dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data} !== {expA, expO, expD}) begin
            bad++; $display("[TB] FAIL dmi_req_payload got=%h/%h/%h exp=%h/%h/%h", dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data, expA, expO, expD); end
         total++; if ({rq1_req_ready, rq0_req_ready} !== 2'b00) begin bad++; $display("[TB] FAIL req_rdy_busy got=%b exp=00", {rq1_req_ready, rq0_req_ready}); end
         total++; if (owner !== 1'(winner) || busy !== 1'b1) begin bad++; $display("[TB] FAIL owner_busy got=%0b/%0b exp=%0d/1", owner, busy, winner); end
         @(posedge clk); #1;
      end
      dmi_req_ready = 0;

      for (int i = 0; i <= waitDelay; i++) begin
         dmi_resp_valid = (i == waitDelay);
         dmi_resp_bits_resp = (i == waitDelay) ? rr : 2'($urandom);
         dmi_resp_bits_data = (i == waitDelay) ? rd : $urandom;
         #1;
         total++; if (dmi_resp_ready !== 1'b1 || dmi_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL wait_hs got=%0b/%0b exp=1/0", dmi_resp_ready, dmi_req_valid); end
         total++; if ({rq1_resp_valid, rq0_resp_valid} !== 2'b00) begin bad++; $display("[TB] FAIL wait_respv got=%b exp=00", {rq1_resp_valid, rq0_resp_valid}); end
         @(posedge clk); #1;
      end
      dmi_resp_valid = 0;

      for (int i = 0; i <= respDelay; i++) begin
         if (winner == 1) begin rq1_resp_ready = (i == respDelay); rq0_resp_ready = 1'($urandom); end
         else begin rq0_resp_ready = (i == respDelay); rq1_resp_ready = 1'($urandom); end
         #1;
         rspV0 = rq0_resp_valid; rspV1 = rq1_resp_valid;
         rspR = winner ? rq1_resp_bits_resp : rq0_resp_bits_resp;
         rspD = winner ? rq1_resp_bits_data : rq0_resp_bits_data;
         total++; if ({rspV1, rspV0} !== (winner ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL resp_route got=%b exp=%b", {rspV1, rspV0}, winner ? 2'b10 : 2'b01); end
         total++; if ({rspR, rspD} !== {rr, rd}) begin bad++; $display("[TB] FAIL resp_payload got=%h/%h exp=%h/%h", rspR, rspD, rr, rd); end
         total++; if ({rq1_req_ready, rq0_req_ready, dmi_resp_ready} !== 3'b000) begin bad++; $display("[TB] FAIL resp_quiet got=%b exp=000", {rq1_req_ready, rq0_req_ready, dmi_resp_ready}); end
         @(posedge clk); #1;
      end
      rq0_resp_ready = 0; rq1_resp_ready = 0;
   endtask

   task automatic test_reset();
      clearInputs();
      reset = 1; rq0_req_valid = 1; rq1_req_valid = 1; dmi_resp_valid = 1;
      @(posedge clk); #1;
      total++; if ({rq0_req_ready, rq1_req_ready, rq0_resp_valid, rq1_resp_valid, dmi_req_valid, dmi_resp_ready, busy, owner} !== 8'h00) begin
         bad++; $display("[TB] FAIL reset_ctrl got=%b exp=00000000", {rq0_req_ready, rq1_req_ready, rq0_resp_valid, rq1_resp_valid, dmi_req_valid, dmi_resp_ready, busy, owner}); end
      total++; if ({dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data, rq0_resp_bits_resp, rq0_resp_bits_data, rq1_resp_bits_data} !== '0) begin
         bad++; $display("[TB] FAIL reset_payload got=%h/%h exp=0", dmi_req_bits_data, rq0_resp_bits_data); end
      clearInputs();
      reset = 0; lastWinner = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      doTxn(1, 0, 0, 0, 0, 0, 7'h11, 2'd0, 32'hDEADBEEF, 1);
      doTxn(1, 0, 0, 0, 0, 0, 7'h11, 2'd0, 32'hDEADBEEF, 1);
   endtask

   task automatic test_contention();
      test_reset();
      for (int i = 0; i < 4; i++) doTxn(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      rq0_req_valid = 0; rq1_req_valid = 0;
   endtask

   task automatic test_stalls();
      doTxn(1, 1, 1, 10, 0, 0, 0, 0, 0, 0);
      doTxn(1, 1, 1, 0, 3, 5, 0, 0, 0, 0);
      rq0_req_valid = 0; rq1_req_valid = 0;
   endtask

   task automatic test_reset_in_wait();
      test_reset();
      rq1_req_valid = 1;
      @(posedge clk); #1;
      rq1_req_valid = 0; dmi_req_ready = 1;
      @(posedge clk); #1;
      dmi_req_ready = 0;
      total++; if (dmi_resp_ready !== 1'b1) begin bad++; $display("[TB] FAIL in_wait got=%0b exp=1", dmi_resp_ready); end
      reset = 1;
      @(posedge clk); #1;
      reset = 0; lastWinner = 1;
      total++; if ({busy, rq0_resp_valid, rq1_resp_valid, dmi_req_valid, dmi_resp_ready} !== 5'b0) begin
         bad++; $display("[TB] FAIL abandon got=%b exp=00000", {busy, rq0_resp_valid, rq1_resp_valid, dmi_req_valid, dmi_resp_ready}); end
      for (int i = 0; i < 2; i++) begin
         dmi_resp_valid = 1; dmi_resp_bits_data = $urandom;
         #1;
         total++; if (dmi_resp_ready !== 1'b0) begin bad++; $display("[TB] FAIL stray_rdy got=%0b exp=0", dmi_resp_ready); end
         @(posedge clk); #1;
      end
      dmi_resp_valid = 0;
      total++; if ({busy, rq0_resp_valid, rq1_resp_valid} !== 3'b0) begin bad++; $display("[TB] FAIL stray_ignored got=%b exp=000", {busy, rq0_resp_valid, rq1_resp_valid}); end
      doTxn(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 24; n++) begin
         v = $urandom_range(1, 3);
         doTxn(v[0], v[1], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0);
      end
      rq0_req_valid = 0; rq1_req_valid = 0;
   endtask

`ifdef DMI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int  n;
      bit  seen;
      test_reset();
      rq0_req_valid = 1;
      @(posedge clk); #1;
      rq0_req_valid = 0; dmi_req_ready = 1; lastWinner = 0;
      @(posedge clk); #1;
      dmi_req_ready = 0;
      n = 0; seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         n++;
         if (rq0_resp_valid === 1'b1) seen = 1;
      end
      total++; if (n !== 8) begin bad++; $display("[TB] FAIL timeout_cycles got=%0d exp=8", n); end
      total++; if ({rq0_resp_bits_resp, rq0_resp_bits_data} !== {2'd2, 32'd0}) begin bad++; $display("[TB] FAIL timeout_resp got=%h/%h exp=2/0", rq0_resp_bits_resp, rq0_resp_bits_data); end
      total++; if (dmi_resp_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_rdy_resp got=%0b exp=1", dmi_resp_ready); end
      rq0_resp_ready = 1;
      @(posedge clk); #1;
      rq0_resp_ready = 0; rq1_req_valid = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({rq1_req_ready, busy, dmi_resp_ready} !== 3'b011) begin bad++; $display("[TB] FAIL drain_hold got=%b exp=011", {rq1_req_ready, busy, dmi_resp_ready}); end
         @(posedge clk); #1;
      end
      dmi_resp_valid = 1; dmi_resp_bits_data = 32'h1234_5678;
      #1;
      total++; if (rq1_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL drain_nogrant got=%0b exp=0", rq1_req_ready); end
      @(posedge clk); #1;
      dmi_resp_valid = 0;
      doTxn(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
`endif

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearInputs();
      reset = 1;
      test_reset();
      test_single();
      test_contention();
      test_stalls();
      test_reset_in_wait();
      test_random();
`ifdef DMI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles spent in WAIT before a synthetic error response is issued (used only with DMI_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 rq0_req_valid/rq0_req_ready  in/out  1/1  requester 0 request handshake.
REQ-005 rq0_req_bits_addr/op/data  in  7/2/32  requester 0 request payload.
REQ-006 rq0_resp_valid/rq0_resp_ready  out/in  1/1  requester 0 response handshake.
REQ-007 rq0_resp_bits_resp/data  out  2/32  requester 0 response payload.
REQ-008 rq1_*: same names, directions and widths as rq0_*, for requester 1.
REQ-009 dmi_req_valid/dmi_req_ready  out/in  1/1  downstream request handshake.
REQ-010 dmi_req_bits_addr/op/data  out  7/2/32  downstream request payload.
REQ-011 dmi_resp_valid/dmi_resp_ready  in/out  1/1  downstream response handshake.
REQ-012 dmi_resp_bits_resp/data  in  2/32  downstream response payload.
REQ-013 busy  out  1  high whenever state is not IDLE or a drain is pending.
REQ-014 owner  out  1  index of the requester that owns the current transaction.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, RESP; exactly one downstream transaction is outstanding at a time.
REQ-016 In IDLE with no drain pending, if any rqN_req_valid is high: grant one requester, assert its rqN_req_ready combinationally in the same cycle, latch addr/op/data and owner, and go to REQ.
REQ-017 Grant rule: if only one requester is valid it wins; if both are valid, the requester that was not granted last (last_grant) wins.
REQ-018 last_grant updates on every grant, so persistent contention alternates 0,1,0,1.
REQ-019 The ungranted requester's req_ready stays 0, and rqN_req_ready is 0 in all states other than IDLE.
REQ-020 REQ: dmi_req_valid=1 with the latched payload, held stable; on dmi_req_ready go to WAIT.
REQ-021 WAIT: dmi_resp_ready=1; on dmi_resp_valid latch resp/data and go to RESP.
REQ-022 RESP: assert owner's rqN_resp_valid with the latched payload, held stable; the other requester's resp_valid is 0; on the owner's resp_ready go to IDLE.
REQ-023 A new grant is possible in the cycle after the RESP handshake, giving a minimum turnaround of 4 cycles per transaction with zero-wait handshakes.
REQ-024 Payload outputs to ports whose valid is low are don't-care but must not be X after reset; drive them from the holding registers.
REQ-025 dmi_resp_valid arriving outside WAIT, with no drain pending, is ignored and dmi_resp_ready stays 0.

Reset
REQ-026 Reset state: state=IDLE, last_grant=1 (requester 0 wins first contention), owner=0, holding registers=0, drain=0, timeout counter=0.
REQ-027 During reset all valid/ready outputs are 0 and busy=0.
REQ-028 Reset asserted mid-transaction abandons it immediately: no response is delivered to the owner and the FSM returns to IDLE.

Configuration
REQ-029 Macro DMI_ARB_TIMEOUT_EN.
REQ-030 With the macro defined: a counter runs in WAIT. When it reaches TIMEOUT_CYCLES-1 without dmi_resp_valid, the block latches resp=2'b10 and data=0, goes to RESP, and sets drain.
REQ-031 While drain is set: dmi_resp_ready=1 in IDLE/REQ/RESP, the next dmi_resp_valid is consumed, discarded and clears drain, and no new grant occurs.
REQ-032 If dmi_resp_valid and the timeout coincide in the same cycle, the real response wins and drain is not set.
REQ-033 With the macro undefined: no counter and no drain logic; WAIT waits indefinitely.

Structure
REQ-034 Shared package dmi_pkg holds: DMI address width (7), op encodings (NOP=0, READ=1, WRITE=2), resp encodings (SUCCESS=0, FAILED=2, BUSY=3), the state enum, and a dmi_req_t/dmi_resp_t payload struct.
REQ-035 One sub-module, dmi_rr_pick: a 2-way round-robin picker with inputs valid[1:0] and last_grant, and outputs grant[1:0] and idx.

Verification
REQ-036 rq0 READ addr=0x11 alone, downstream resp=0 data=0xDEADBEEF -> rq0 gets resp 0/0xDEADBEEF, rq1_resp_valid stays 0, 4-cycle turnaround.
REQ-037 rq0 and rq1 both valid continuously for 4 transactions -> grant order 0,1,0,1 and each response is routed to its owner only.
REQ-038 dmi_req_ready held low 10 cycles -> dmi_req payload stable throughout, no second grant, both req_ready 0.
REQ-039 Reset asserted in WAIT -> next cycle state IDLE, all valids 0, a later dmi_resp_valid is ignored.
REQ-040 DMI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, no downstream response -> owner gets resp=2 data=0 after 8 WAIT cycles; a late response is drained; the next grant occurs only after the drain.
REQ-041 Owner holds resp_ready low 5 cycles in RESP -> response held stable and no new grant until the handshake.
